// File: rtl/tlb_refill_walker.sv
// -----------------------------------------------------------------------------
// tlb_refill_walker
//   Hardware TLB refill engine for the instruction (IME) and data (DME) memory
//   engines. On a TLB miss it reads one PTE line from a single-level page table
//   through the arbiter's request/response id scheme. It then either writes the
//   translation into the TLB that missed or raises a page fault.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   i_itlb_miss/_vaddr    instruction TLB miss level and missing VA
//   i_dtlb_miss/_vaddr    data TLB miss level and missing VA (wins a tie)
//   o_mem_enable/_addr    PTE line read request, held until i_mem_grant
//   i_mem_grant           arbiter accepted the request this cycle
//   i_mem_id_request      id assigned by the arbiter on the grant cycle
//   i_mem_enable          memory response valid
//   i_mem_id_response     id of the response
//   i_mem_data            response line, little-endian 32-bit words
//   o_mem_ack             ack of a consumed response, same cycle as the response
//   o_tlb_vpn/_ppn        translation, driven with the write strobe
//   o_itlb_write_enable   1-cycle write strobe to the instruction TLB
//   o_dtlb_write_enable   1-cycle write strobe to the data TLB
//   o_fault               1-cycle page fault pulse
//   o_fault_is_data       fault source, 1=data, valid with o_fault
//   o_busy                walker is not idle
//   o_dbg_state           current FSM state encoding, for checkers
//
// Handshake: a request is transferred on a cycle where o_mem_enable and
// i_mem_grant are both high; o_mem_enable holds o_mem_addr stable until then.
// A response is consumed on a cycle where i_mem_enable is high and
// i_mem_id_response matches the granted id while waiting; o_mem_ack marks
// exactly those cycles.
// -----------------------------------------------------------------------------
module tlb_refill_walker #(
  parameter int                VA_WIDTH      = 32,
  parameter int                PA_WIDTH      = 20,
  parameter int                PAGE_BITS     = 12,
  parameter int                PT_INDEX_BITS = 10,
  parameter logic [PA_WIDTH-1:0] PT_BASE     = 20'h10000,
  parameter int                CACHE_BYTES   = 16,
  parameter int                ID_WIDTH      = 2,
  parameter int                TIMEOUT       = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_itlb_miss,
  input  logic [VA_WIDTH-1:0]           i_itlb_vaddr,
  input  logic                          i_dtlb_miss,
  input  logic [VA_WIDTH-1:0]           i_dtlb_vaddr,
  output logic                          o_mem_enable,
  output logic [PA_WIDTH-1:0]           o_mem_addr,
  input  logic                          i_mem_grant,
  input  logic [ID_WIDTH-1:0]           i_mem_id_request,
  input  logic                          i_mem_enable,
  input  logic [ID_WIDTH-1:0]           i_mem_id_response,
  input  logic [CACHE_BYTES*8-1:0]      i_mem_data,
  output logic                          o_mem_ack,
  output logic [VA_WIDTH-PAGE_BITS-1:0] o_tlb_vpn,
  output logic [PA_WIDTH-PAGE_BITS-1:0] o_tlb_ppn,
  output logic                          o_itlb_write_enable,
  output logic                          o_dtlb_write_enable,
  output logic                          o_fault,
  output logic                          o_fault_is_data,
  output logic                          o_busy,
  output logic [2:0]                    o_dbg_state
);

  localparam int VPN_W     = VA_WIDTH - PAGE_BITS;
  localparam int PPN_W     = PA_WIDTH - PAGE_BITS;
  localparam int LINE_BITS = $clog2(CACHE_BYTES);
  localparam int WORDS     = CACHE_BYTES / 4;
  localparam int WSEL_W    = LINE_BITS - 2;
  localparam int TMR_W     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t              state_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [VPN_W-1:0]    vpn_q;
  logic                src_data_q;
  logic [TMR_W-1:0]    timer_q;

  // Byte address of the PTE for a VPN; wraps naturally at PA_WIDTH bits.
  function automatic logic [PA_WIDTH-1:0] pte_addr_of(input logic [VPN_W-1:0] vpn);
    pte_addr_of = PT_BASE + {{(PA_WIDTH-PT_INDEX_BITS-2){1'b0}},
                             vpn[PT_INDEX_BITS-1:0], 2'b00};
  endfunction

  // Miss selection in IDLE: data side wins a simultaneous miss.
  logic [VPN_W-1:0]    cand_vpn;
  logic [PA_WIDTH-1:0] cand_pte_addr;
  assign cand_vpn      = i_dtlb_miss ? i_dtlb_vaddr[VA_WIDTH-1:PAGE_BITS]
                                     : i_itlb_vaddr[VA_WIDTH-1:PAGE_BITS];
  assign cand_pte_addr = pte_addr_of(cand_vpn);

  // Word of the returned line holding the PTE of the walk in flight.
  logic [PA_WIDTH-1:0] cur_pte_addr;
  logic [WSEL_W-1:0]   wsel;
  logic [31:0]         pte_word;
  assign cur_pte_addr = pte_addr_of(vpn_q);
  assign wsel         = cur_pte_addr[LINE_BITS-1:2];

  always_comb begin
    pte_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (wsel == WSEL_W'(w)) pte_word = i_mem_data[w*32 +: 32];
    end
  end

  logic             pte_valid;
  logic [PPN_W-1:0] pte_ppn;
  assign pte_valid = pte_word[0];
  assign pte_ppn   = pte_word[PA_WIDTH-1:PAGE_BITS];

  // The ack has to land in the same cycle as the response, so it is decoded
  // from the registered state rather than registered itself. Outside WAIT
  // (including right after a reset) no response can ever be acked.
  logic resp_match;
  assign resp_match = (state_q == S_WAIT) && i_mem_enable && (i_mem_id_response == id_q);
  assign o_mem_ack  = resp_match;
  assign o_dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q             <= S_IDLE;
      id_q                <= '0;
      vpn_q               <= '0;
      src_data_q          <= 1'b0;
      timer_q             <= '0;
      o_mem_enable        <= 1'b0;
      o_mem_addr          <= '0;
      o_tlb_vpn           <= '0;
      o_tlb_ppn           <= '0;
      o_itlb_write_enable <= 1'b0;
      o_dtlb_write_enable <= 1'b0;
      o_fault             <= 1'b0;
      o_fault_is_data     <= 1'b0;
      o_busy              <= 1'b0;
    end else begin
      // Strobes and the translation they carry are single-cycle pulses.
      o_itlb_write_enable <= 1'b0;
      o_dtlb_write_enable <= 1'b0;
      o_fault             <= 1'b0;
      o_fault_is_data     <= 1'b0;
      o_tlb_vpn           <= '0;
      o_tlb_ppn           <= '0;
      case (state_q)
        S_IDLE: begin
          if (i_dtlb_miss || i_itlb_miss) begin
            vpn_q        <= cand_vpn;
            src_data_q   <= i_dtlb_miss;
            o_mem_enable <= 1'b1;
            o_mem_addr   <= {cand_pte_addr[PA_WIDTH-1:LINE_BITS], {LINE_BITS{1'b0}}};
            o_busy       <= 1'b1;
            state_q      <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_mem_grant) begin
            id_q         <= i_mem_id_request;
            timer_q      <= '0;
            o_mem_enable <= 1'b0;
            o_mem_addr   <= '0;
            state_q      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A matching response beats the timeout in the same cycle.
          if (resp_match) begin
            if (pte_valid) begin
              o_tlb_vpn           <= vpn_q;
              o_tlb_ppn           <= pte_ppn;
              o_dtlb_write_enable <= src_data_q;
              o_itlb_write_enable <= !src_data_q;
            end else begin
              o_fault         <= 1'b1;
              o_fault_is_data <= src_data_q;
            end
            state_q <= S_DONE;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            o_fault         <= 1'b1;
            o_fault_is_data <= src_data_q;
            state_q         <= S_FAULT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        // Both terminal states last one cycle; the following IDLE cycle lets
        // the TLB absorb its write before a still-high miss is re-sampled.
        S_DONE, S_FAULT: begin
          o_busy  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          o_mem_enable <= 1'b0;
          o_busy       <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{i_itlb_vaddr[PAGE_BITS-1:0], i_dtlb_vaddr[PAGE_BITS-1:0],
                         pte_word[31:PA_WIDTH], pte_word[PAGE_BITS-1:1],
                         cur_pte_addr[PA_WIDTH-1:LINE_BITS], cur_pte_addr[1:0]};

endmodule

// File: tb/tb_tlb_refill_walker.sv
module tb_tlb_refill_walker;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_itlb_miss = 1'b0;
  logic [31:0]  i_itlb_vaddr = '0;
  logic         i_dtlb_miss = 1'b0;
  logic [31:0]  i_dtlb_vaddr = '0;
  logic         o_mem_enable;
  logic [19:0]  o_mem_addr;
  logic         i_mem_grant = 1'b0;
  logic [1:0]   i_mem_id_request = '0;
  logic         i_mem_enable = 1'b0;
  logic [1:0]   i_mem_id_response = '0;
  logic [127:0] i_mem_data = '0;
  logic         o_mem_ack;
  logic [19:0]  o_tlb_vpn;
  logic [7:0]   o_tlb_ppn;
  logic         o_itlb_write_enable;
  logic         o_dtlb_write_enable;
  logic         o_fault;
  logic         o_fault_is_data;
  logic         o_busy;
  logic [2:0]   o_dbg_state;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tlb_refill_walker dut (
    .clk(clk), .rst(rst),
    .i_itlb_miss(i_itlb_miss), .i_itlb_vaddr(i_itlb_vaddr),
    .i_dtlb_miss(i_dtlb_miss), .i_dtlb_vaddr(i_dtlb_vaddr),
    .o_mem_enable(o_mem_enable), .o_mem_addr(o_mem_addr),
    .i_mem_grant(i_mem_grant), .i_mem_id_request(i_mem_id_request),
    .i_mem_enable(i_mem_enable), .i_mem_id_response(i_mem_id_response),
    .i_mem_data(i_mem_data), .o_mem_ack(o_mem_ack),
    .o_tlb_vpn(o_tlb_vpn), .o_tlb_ppn(o_tlb_ppn),
    .o_itlb_write_enable(o_itlb_write_enable), .o_dtlb_write_enable(o_dtlb_write_enable),
    .o_fault(o_fault), .o_fault_is_data(o_fault_is_data),
    .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_strobes"}, {o_itlb_write_enable, o_dtlb_write_enable, o_fault}, 3'b000);
  endtask

  // ---------------- reference model ----------------
  // A walk reads word ((base + 4*index) mod 2^20) of the page table; the
  // request goes to its 16-byte line and the PTE is that word of the line.
  function automatic int unsigned model_pte_byte(input logic [31:0] va);
    int unsigned idx = (va >> 12) % 1024;
    return (32'h10000 + idx * 4) % (1 << 20);
  endfunction

  function automatic logic [19:0] model_line_addr(input logic [31:0] va);
    int unsigned b = model_pte_byte(va);
    return 20'(b - (b % 16));
  endfunction

  function automatic int model_word(input logic [31:0] va);
    return int'((model_pte_byte(va) % 16) / 4);
  endfunction

  // ---------------- driver ----------------
  // Runs one complete walk from an IDLE cycle: the bench acts as arbiter and
  // memory and compares every observable step against the given expectation.
  task automatic run_walk(input bit is_data, input logic [31:0] va, input logic [127:0] line,
                          input logic [19:0] exp_addr, input bit exp_valid,
                          input logic [19:0] exp_vpn, input logic [7:0] exp_ppn,
                          input int gdly, input int rdly, input logic [1:0] gid,
                          input bit wrong_id);
    logic [1:0] bad_id;
    bad_id = gid - 2'd1;
    if (is_data) begin i_dtlb_miss = 1'b1; i_dtlb_vaddr = va; end
    else         begin i_itlb_miss = 1'b1; i_itlb_vaddr = va; end
    tick();
    // Dropping the miss now must not cancel the walk.
    i_dtlb_miss = 1'b0;
    i_itlb_miss = 1'b0;
    check("req_enable", o_mem_enable, 1'b1);
    check("req_addr", o_mem_addr, exp_addr);
    check("req_busy", o_busy, 1'b1);
    for (int k = 0; k < gdly; k++) begin
      tick();
      check("req_hold", {o_mem_enable, o_mem_addr}, {1'b1, exp_addr});
    end
    i_mem_grant = 1'b1;
    i_mem_id_request = gid;
    tick();
    i_mem_grant = 1'b0;
    i_mem_id_request = '0;
    check("wait_enable_low", o_mem_enable, 1'b0);
    for (int k = 0; k < rdly; k++) begin
      if (wrong_id) begin
        i_mem_enable = 1'b1;
        i_mem_id_response = bad_id;
        i_mem_data = line;
        #1;
        check("wrong_id_no_ack", o_mem_ack, 1'b0);
      end
      tick();
      i_mem_enable = 1'b0;
      check_quiet("wait");
      check("wait_busy", o_busy, 1'b1);
    end
    i_mem_enable = 1'b1;
    i_mem_id_response = gid;
    i_mem_data = line;
    #1;
    check("resp_ack", o_mem_ack, 1'b1);
    tick();
    i_mem_enable = 1'b0;
    i_mem_data = '0;
    check("done_dtlb_we", o_dtlb_write_enable, exp_valid && is_data);
    check("done_itlb_we", o_itlb_write_enable, exp_valid && !is_data);
    check("done_fault", {o_fault, o_fault_is_data}, {!exp_valid, !exp_valid && is_data});
    check("done_ack_low", o_mem_ack, 1'b0);
    if (exp_valid) check("done_xlate", {o_tlb_vpn, o_tlb_ppn}, {exp_vpn, exp_ppn});
    tick();
    check("idle_busy", o_busy, 1'b0);
    check_quiet("idle");
  endtask

  typedef struct {
    bit          is_data;
    logic [31:0] va;
    logic [31:0] pte;
    int          word;
    logic [19:0] exp_addr;
    bit          exp_valid;
    logic [19:0] exp_vpn;
    logic [7:0]  exp_ppn;
    logic [1:0]  gid;
    bit          wrong_id;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [127:0] line;
    logic [31:0]  pte;

    vecs[0] = '{1'b1, 32'h00003ABC, 32'h00045001, 3, 20'h10000, 1'b1, 20'h00003, 8'h45, 2'd0, 1'b0};
    vecs[1] = '{1'b0, 32'h00004000, 32'h000AB003, 0, 20'h10010, 1'b1, 20'h00004, 8'hAB, 2'd1, 1'b0};
    vecs[2] = '{1'b0, 32'h00007FFF, 32'h00012000, 3, 20'h10010, 1'b0, 20'h00007, 8'h00, 2'd3, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFFF123, 32'h00000000, 3, 20'h10FF0, 1'b0, 20'hFFFFF, 8'h00, 2'd0, 1'b0};
    vecs[4] = '{1'b1, 32'h12345678, 32'hFFFFFFFF, 1, 20'h10D10, 1'b1, 20'h12345, 8'hFF, 2'd2, 1'b1};
    vecs[5] = '{1'b0, 32'h00C01000, 32'h76543001, 1, 20'h10000, 1'b1, 20'h00C01, 8'h43, 2'd2, 1'b1};

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {o_mem_enable, o_mem_addr, o_mem_ack, o_tlb_vpn, o_tlb_ppn,
                          o_itlb_write_enable, o_dtlb_write_enable, o_fault,
                          o_fault_is_data, o_busy}, '0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // ---------------- table-driven walks ----------------
    for (int v = 0; v < 6; v++) begin
      line = rand_line();
      line[vecs[v].word*32 +: 32] = vecs[v].pte;
      run_walk(vecs[v].is_data, vecs[v].va, line, vecs[v].exp_addr, vecs[v].exp_valid,
               vecs[v].exp_vpn, vecs[v].exp_ppn, 0, vecs[v].wrong_id ? 2 : 0,
               vecs[v].gid, vecs[v].wrong_id);
    end

    // ---------------- simultaneous misses: data first, then instruction ----------------
    i_dtlb_miss = 1'b1; i_dtlb_vaddr = 32'h00005000;
    i_itlb_miss = 1'b1; i_itlb_vaddr = 32'h00009000;
    tick();
    i_dtlb_miss = 1'b0;
    check("both_req_addr", o_mem_addr, 20'h10010);
    i_mem_grant = 1'b1; i_mem_id_request = 2'd0;
    tick();
    i_mem_grant = 1'b0;
    line = '0; line[63:32] = 32'h00011001;
    i_mem_enable = 1'b1; i_mem_id_response = 2'd0; i_mem_data = line;
    tick();
    i_mem_enable = 1'b0;
    check("both_first_we", {o_dtlb_write_enable, o_itlb_write_enable, o_tlb_ppn}, {2'b10, 8'h11});
    tick();
    check("both_gap", {o_busy, o_mem_enable}, 2'b00);
    tick();
    i_itlb_miss = 1'b0;
    check("both_second_req", {o_mem_enable, o_mem_addr, o_busy}, {1'b1, 20'h10020, 1'b1});
    i_mem_grant = 1'b1; i_mem_id_request = 2'd1;
    tick();
    i_mem_grant = 1'b0;
    line = '0; line[63:32] = 32'h00022001;
    i_mem_enable = 1'b1; i_mem_id_response = 2'd1; i_mem_data = line;
    tick();
    i_mem_enable = 1'b0;
    check("both_second_we", {o_dtlb_write_enable, o_itlb_write_enable, o_tlb_vpn, o_tlb_ppn},
          {2'b01, 20'h00009, 8'h22});
    tick();
    check("both_end_busy", o_busy, 1'b0);

    // ---------------- timeout ----------------
    begin
      bit early;
      early = 1'b0;
      i_dtlb_miss = 1'b1; i_dtlb_vaddr = 32'h00001000;
      tick();
      i_dtlb_miss = 1'b0;
      i_mem_grant = 1'b1; i_mem_id_request = 2'd3;   // grant cycle g
      tick();
      i_mem_grant = 1'b0;
      for (int k = 1; k <= 64; k++) begin            // cycles g+1 .. g+64
        if (o_fault || !o_busy) early = 1'b1;
        tick();
      end
      check("timeout_not_early", early, 1'b0);
      check("timeout_fault", {o_fault, o_fault_is_data, o_busy}, 3'b111);
      tick();
      check("timeout_busy_falls", {o_busy, o_fault}, 2'b00);
    end

    // ---------------- asynchronous reset during WAIT ----------------
    i_itlb_miss = 1'b1; i_itlb_vaddr = 32'h00002000;
    tick();
    i_itlb_miss = 1'b0;
    i_mem_grant = 1'b1; i_mem_id_request = 2'd2;
    tick();
    i_mem_grant = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_outputs", {o_mem_enable, o_mem_addr, o_mem_ack, o_tlb_vpn, o_tlb_ppn,
                              o_itlb_write_enable, o_dtlb_write_enable, o_fault,
                              o_fault_is_data, o_busy}, '0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    line = '0; line[31:0] = 32'h00033001;
    i_mem_enable = 1'b1; i_mem_id_response = 2'd2; i_mem_data = line;
    #1;
    check("post_rst_no_ack", o_mem_ack, 1'b0);
    tick();
    i_mem_enable = 1'b0;
    check_quiet("post_rst");
    check("post_rst_busy", o_busy, 1'b0);

    // ---------------- randomized walks against the model ----------------
    for (int n = 0; n < 40; n++) begin
      bit          is_data;
      logic [31:0] va;
      int          w;
      is_data = 1'($urandom_range(0, 1));
      va      = $urandom();
      line    = rand_line();
      w       = model_word(va);
      line[w*32] = ($urandom_range(0, 3) != 0);
      pte     = line[w*32 +: 32];
      run_walk(is_data, va, line, model_line_addr(va), pte[0], 20'(va >> 12),
               8'((pte >> 12) % 256), int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
